// File: rtl/vx_imem_responder.sv
// vx_imem_responder
//   Word-addressed instruction memory model with a fixed read latency and
//   credit-based flow control. Writes merge bytes into the array and produce
//   no response. Reads are launched into a LATENCY-deep valid/data pipeline
//   whose output lands in an in-order response FIFO. Responses are always
//   taken from a register, so there is no combinational request-to-response
//   path.
//
// Ports
//   clk_i          clock, all logic on the rising edge
//   reset_i        synchronous reset, active low
//   req_valid_i    request present
//   req_rw_i       1 = write, 0 = read
//   req_addr_i     word address; only the low log2(DEPTH) bits index memory
//   req_byteen_i   byte enables for writes
//   req_data_i     write data
//   req_tag_i      request tag, echoed back on the matching response
//   req_ready_o    a read credit is available
//   rsp_valid_o    response FIFO head is valid
//   rsp_data_o     read data at FIFO head
//   rsp_tag_o      tag at FIFO head
//   rsp_ready_i    consumer takes the head response
//   busy_o         at least one read is in flight or queued
module vx_imem_responder #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 30,
  parameter int TAG_WIDTH       = 8,
  parameter int DEPTH           = 1024,
  parameter int LATENCY         = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    req_valid_i,
  input  logic                    req_rw_i,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [DATA_WIDTH/8-1:0] req_byteen_i,
  input  logic [DATA_WIDTH-1:0]   req_data_i,
  input  logic [TAG_WIDTH-1:0]    req_tag_i,
  output logic                    req_ready_o,
  output logic                    rsp_valid_o,
  output logic [DATA_WIDTH-1:0]   rsp_data_o,
  output logic [TAG_WIDTH-1:0]    rsp_tag_o,
  input  logic                    rsp_ready_i,
  output logic                    busy_o
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic [IDX_W-1:0] idx;
  logic             rd_accept;
  logic             wr_accept;
  logic             push;
  logic             pop;

  // Upper address bits alias onto the array.
  assign idx = req_addr_i[IDX_W-1:0];
  if (ADDR_WIDTH > IDX_W) begin : g_alias
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr_i[ADDR_WIDTH-1:IDX_W];
  end

  // ---------------------------------------------------------------------
  // Credits
  // ---------------------------------------------------------------------
  logic [CNT_W-1:0] outstanding_q, outstanding_d;

  assign req_ready_o = (outstanding_q < CNT_W'(MAX_OUTSTANDING));
  assign busy_o      = (outstanding_q != '0);
  assign rd_accept   = req_valid_i && req_ready_o && !req_rw_i;
  assign wr_accept   = req_valid_i && req_ready_o &&  req_rw_i;

  always_comb begin
    outstanding_d = outstanding_q;
    case ({rd_accept, pop})
      2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
      2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  // ---------------------------------------------------------------------
  // Memory array (deliberately not reset: contents survive reset)
  // ---------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr_accept) begin
      for (int b = 0; b < BYTES; b++) begin
        if (req_byteen_i[b]) begin
          mem_q[idx][b*8 +: 8] <= req_data_i[b*8 +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Read pipeline: stage 0 captures the array word at the accept edge, so a
  // read right after a write to the same word sees the merged data.
  // ---------------------------------------------------------------------
  logic [LATENCY-1:0]    pipe_vld_q, pipe_vld_d;
  logic [DATA_WIDTH-1:0] pipe_data_q [LATENCY];
  logic [TAG_WIDTH-1:0]  pipe_tag_q  [LATENCY];

  always_comb begin
    pipe_vld_d    = '0;
    pipe_vld_d[0] = rd_accept;
    for (int s = 1; s < LATENCY; s++) begin
      pipe_vld_d[s] = pipe_vld_q[s-1];
    end
  end

  // Payload needs no reset; only the valid bits qualify it.
  always_ff @(posedge clk_i) begin
    pipe_data_q[0] <= mem_q[idx];
    pipe_tag_q[0]  <= req_tag_i;
    for (int s = 1; s < LATENCY; s++) begin
      pipe_data_q[s] <= pipe_data_q[s-1];
      pipe_tag_q[s]  <= pipe_tag_q[s-1];
    end
  end

  // ---------------------------------------------------------------------
  // Response FIFO. The pipeline never stalls: credits bound pipeline plus
  // FIFO occupancy to MAX_OUTSTANDING, so a push always finds space.
  // ---------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] fifo_data_q [MAX_OUTSTANDING];
  logic [TAG_WIDTH-1:0]  fifo_tag_q  [MAX_OUTSTANDING];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      fifo_cnt_q, fifo_cnt_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(MAX_OUTSTANDING - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  assign push        = pipe_vld_q[LATENCY-1];
  assign rsp_valid_o = (fifo_cnt_q != '0);
  assign rsp_data_o  = fifo_data_q[rd_ptr_q];
  assign rsp_tag_o   = fifo_tag_q[rd_ptr_q];
  assign pop         = rsp_valid_o && rsp_ready_i;

  always_comb begin
    wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= pipe_data_q[LATENCY-1];
      fifo_tag_q[wr_ptr_q]  <= pipe_tag_q[LATENCY-1];
    end
  end

  // ---------------------------------------------------------------------
  // Control state with synchronous active-low reset. Clearing the pipeline
  // valids and FIFO pointers drops every in-flight and queued read.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      outstanding_q <= '0;
      pipe_vld_q    <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fifo_cnt_q    <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      pipe_vld_q    <= pipe_vld_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fifo_cnt_q    <= fifo_cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      assert (!(push && !pop && (fifo_cnt_q == CNT_W'(MAX_OUTSTANDING))));
      assert (!(rd_accept && !pop && (outstanding_q == CNT_W'(MAX_OUTSTANDING))));
      assert (!(pop && (outstanding_q == '0)));
    end
  end

endmodule
